// File: rtl/direction_matrix_ram.sv
// Direction memory for the Needleman-Wunsch core.
// Holds one direction symbol per cell of the (N+1)x(N+1) score matrix,
// writes the gap border itself, accepts fill-stage writes, serves debug
// reads and walks the traceback path from (N,N) to (0,0) over valid/ready.
module direction_matrix_ram #(
  parameter  int unsigned N     = 5,
  parameter  int unsigned SYM_W = 3,
  localparam int unsigned AW    = $clog2(N+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init_start,
  output logic             init_done,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_i,
  input  logic [AW-1:0]    wr_j,
  input  logic [SYM_W-1:0] wr_sym,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_i,
  input  logic [AW-1:0]    rd_j,
  output logic [SYM_W-1:0] rd_sym,
  input  logic             tb_start,
  output logic             tb_busy,
  output logic             tb_valid,
  input  logic             tb_ready,
  output logic [SYM_W-1:0] tb_sym,
  output logic [AW-1:0]    tb_i,
  output logic [AW-1:0]    tb_j,
  output logic             tb_last,
  output logic             err
);

  localparam int unsigned DEPTH = (N+1)*(N+1);
  localparam int unsigned MW    = $clog2(DEPTH);
  localparam int unsigned KW    = $clog2(2*N+1);

  localparam logic [SYM_W-1:0] SYM_DIAG = SYM_W'(3'b100);
  localparam logic [SYM_W-1:0] SYM_UP   = SYM_W'(3'b010);
  localparam logic [SYM_W-1:0] SYM_LEFT = SYM_W'(3'b001);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_TB_FETCH, S_TB_OUT} state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [AW-1:0]    ti_q, ti_d, tj_q, tj_d;
  logic [SYM_W-1:0] tsym_q;
  logic [SYM_W-1:0] rd_sym_q;
  logic             init_done_q, init_done_d;
  logic             err_q, err_d;
  logic             valid, last, bad;
  logic [AW-1:0]    ni, nj;

  logic [SYM_W-1:0] mem [DEPTH];
  logic             mem_we;
  logic [MW-1:0]    mem_waddr;
  logic [SYM_W-1:0] mem_wdata;
  int unsigned      kk;

  function automatic logic [MW-1:0] lin(input logic [AW-1:0] i, input logic [AW-1:0] j);
    lin = MW'(i) * MW'(N+1) + MW'(j);
  endfunction

  function automatic logic in_range(input logic [AW-1:0] i, input logic [AW-1:0] j);
    in_range = (i <= AW'(N)) && (j <= AW'(N));
  endfunction

  // Next-state logic, traceback move decode and handshake outputs
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    ti_d        = ti_q;
    tj_d        = tj_q;
    err_d       = err_q;
    init_done_d = 1'b0;
    valid       = 1'b0;
    last        = 1'b0;
    bad         = 1'b0;
    ni          = ti_q;
    nj          = tj_q;
    case (state_q)
      S_IDLE: begin
        if (init_start) begin
          state_d = S_INIT;
          k_d     = '0;
          err_d   = 1'b0;
        end else if (tb_start) begin
          state_d = S_TB_FETCH;
          ti_d    = AW'(N);
          tj_d    = AW'(N);
          err_d   = 1'b0;
        end
      end
      S_INIT: begin
        if (k_q == KW'(2*N)) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      S_TB_FETCH: state_d = S_TB_OUT;
      S_TB_OUT: begin
        case (tsym_q)
          SYM_DIAG: begin
            if (ti_q == '0 || tj_q == '0) bad = 1'b1;
            else begin
              ni = ti_q - AW'(1);
              nj = tj_q - AW'(1);
            end
          end
          SYM_UP: begin
            if (ti_q == '0) bad = 1'b1;
            else ni = ti_q - AW'(1);
          end
          SYM_LEFT: begin
            if (tj_q == '0) bad = 1'b1;
            else nj = tj_q - AW'(1);
          end
          default: bad = 1'b1;
        endcase
        if (bad) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          valid = 1'b1;
          last  = (ni == '0) && (nj == '0);
          if (tb_ready) begin
            ti_d    = ni;
            tj_d    = nj;
            state_d = last ? S_IDLE : S_TB_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Single write port: border init has priority, fill writes only in IDLE
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
    kk        = 32'(k_q);
    if (state_q == S_INIT) begin
      mem_we = 1'b1;
      if (kk == 0) begin
        mem_waddr = '0;
        mem_wdata = '0;
      end else if (kk <= N) begin
        mem_waddr = MW'(kk);
        mem_wdata = SYM_LEFT;
      end else begin
        mem_waddr = MW'((kk - N) * (N + 1));
        mem_wdata = SYM_UP;
      end
    end else if (state_q == S_IDLE && wr_en && in_range(wr_i, wr_j)) begin
      mem_we    = 1'b1;
      mem_waddr = lin(wr_i, wr_j);
      mem_wdata = wr_sym;
    end
  end

  // Storage array, deliberately left out of reset
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Control registers and the two registered read ports
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      ti_q        <= '0;
      tj_q        <= '0;
      tsym_q      <= '0;
      rd_sym_q    <= '0;
      init_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      ti_q        <= ti_d;
      tj_q        <= tj_d;
      init_done_q <= init_done_d;
      err_q       <= err_d;
      if (state_q == S_IDLE && rd_en)
        rd_sym_q <= in_range(rd_i, rd_j) ? mem[lin(rd_i, rd_j)] : '0;
      if (state_q == S_TB_FETCH)
        tsym_q <= mem[lin(ti_q, tj_q)];
    end
  end

  // err is raised combinationally so it is visible in the failing TB_OUT cycle
  assign err       = err_q | bad;
  assign init_done = init_done_q;
  assign rd_sym    = rd_sym_q;
  assign tb_busy   = (state_q == S_TB_FETCH) || (state_q == S_TB_OUT);
  assign tb_valid  = valid;
  assign tb_last   = last;
  assign tb_sym    = tsym_q;
  assign tb_i      = ti_q;
  assign tb_j      = tj_q;

endmodule

// File: tb/tb_direction_matrix_ram.sv
// Randomised self-checking bench for direction_matrix_ram with a cell-array
// reference model and a path walker that derives the expected beat stream.
module tb_direction_matrix_ram;
  localparam int N  = 5;
  localparam int AW = $clog2(N+1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          init_start = 1'b0, init_done;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_i = '0, wr_j = '0;
  logic [2:0]    wr_sym = '0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_i = '0, rd_j = '0;
  logic [2:0]    rd_sym;
  logic          tb_start = 1'b0, tb_busy, tb_valid, tb_ready = 1'b0;
  logic [2:0]    tb_sym;
  logic [AW-1:0] tb_i, tb_j;
  logic          tb_last, err;

  direction_matrix_ram #(.N(N), .SYM_W(3)) dut (
    .clk(clk), .rst(rst),
    .init_start(init_start), .init_done(init_done),
    .wr_en(wr_en), .wr_i(wr_i), .wr_j(wr_j), .wr_sym(wr_sym),
    .rd_en(rd_en), .rd_i(rd_i), .rd_j(rd_j), .rd_sym(rd_sym),
    .tb_start(tb_start), .tb_busy(tb_busy), .tb_valid(tb_valid), .tb_ready(tb_ready),
    .tb_sym(tb_sym), .tb_i(tb_i), .tb_j(tb_j), .tb_last(tb_last), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {int i; int j; int s; bit last;} beat_t;

  int    checks = 0;
  int    errors = 0;
  int    refm [N+1][N+1];
  beat_t expq [$];
  bit    experr;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_init_done"}, int'(init_done), 0);
    check({tag, "_rd_sym"},    int'(rd_sym), 0);
    check({tag, "_tb_busy"},   int'(tb_busy), 0);
    check({tag, "_tb_valid"},  int'(tb_valid), 0);
    check({tag, "_tb_sym"},    int'(tb_sym), 0);
    check({tag, "_tb_i"},      int'(tb_i), 0);
    check({tag, "_tb_j"},      int'(tb_j), 0);
    check({tag, "_tb_last"},   int'(tb_last), 0);
    check({tag, "_err"},       int'(err), 0);
  endtask

  task automatic model_border();
    refm[0][0] = 0;
    for (int j = 1; j <= N; j++) refm[0][j] = 1;
    for (int i = 1; i <= N; i++) refm[i][0] = 2;
  endtask

  task automatic do_write(input int i, input int j, input int s);
    wr_en = 1'b1; wr_i = AW'(i); wr_j = AW'(j); wr_sym = 3'(s);
    step();
    wr_en = 1'b0;
    if (i <= N && j <= N) refm[i][j] = s;
  endtask

  task automatic do_read(input int i, input int j);
    rd_en = 1'b1; rd_i = AW'(i); rd_j = AW'(j);
    step();
    rd_en = 1'b0;
    check("rd_sym", int'(rd_sym), (i <= N && j <= N) ? refm[i][j] : 0);
  endtask

  task automatic do_init();
    int n;
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    check("init_clears_err", int'(err), 0);
    n = 0;
    while (!init_done && n < 50) begin
      step();
      n++;
    end
    check("init_latency", n, 2*N+1);
    step();
    check("init_done_pulse", int'(init_done), 0);
    model_border();
  endtask

  // Walk the model matrix from (N,N) following the direction rules.
  task automatic build_expect();
    int ci, cj, s, di, dj;
    bit ok;
    expq.delete();
    experr = 1'b0;
    ci = N; cj = N;
    for (int n = 0; n < 4*N; n++) begin
      s = refm[ci][cj];
      di = 0; dj = 0; ok = 1'b1;
      if (s == 4) begin di = 1; dj = 1; end
      else if (s == 2) di = 1;
      else if (s == 1) dj = 1;
      else ok = 1'b0;
      if (ok && (ci < di || cj < dj)) ok = 1'b0;
      if (!ok) begin
        experr = 1'b1;
        break;
      end
      expq.push_back('{i: ci, j: cj, s: s, last: (ci-di == 0 && cj-dj == 0)});
      ci -= di; cj -= dj;
      if (ci == 0 && cj == 0) break;
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: ready low 3 cycles on beat 1
  task automatic run_trace(input int mode);
    bit    done, rdy;
    int    beat, hold;
    beat_t b;
    build_expect();
    tb_start = 1'b1;
    step();
    tb_start = 1'b0;
    check("fetch_busy", int'(tb_busy), 1);
    check("fetch_valid", int'(tb_valid), 0);
    step();
    done = 1'b0; beat = 0; hold = 0;
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      if (err) begin
        check("err_flag", int'(err), int'(experr));
        check("err_beats_left", expq.size(), 0);
        check("err_valid", int'(tb_valid), 0);
        step();
        check("err_busy_after", int'(tb_busy), 0);
        check("err_sticky", int'(err), 1);
        done = 1'b1;
      end else if (tb_valid) begin
        if (expq.size() == 0) begin
          check("extra_beat", int'(tb_valid), 0);
          done = 1'b1;
        end else begin
          check("beat_i", int'(tb_i), expq[0].i);
          check("beat_j", int'(tb_j), expq[0].j);
          check("beat_sym", int'(tb_sym), expq[0].s);
          check("beat_last", int'(tb_last), int'(expq[0].last));
          if (mode == 0) rdy = 1'b1;
          else if (mode == 1) rdy = 1'($urandom_range(0, 1));
          else begin
            rdy = !(beat == 1 && hold < 3);
            if (!rdy) hold++;
          end
          tb_ready = rdy;
          step();
          tb_ready = 1'b0;
          if (rdy) begin
            b = expq.pop_front();
            beat++;
            if (b.last) begin
              check("end_busy", int'(tb_busy), 0);
              check("end_valid", int'(tb_valid), 0);
              check("end_err", int'(err), int'(experr));
              done = 1'b1;
            end else begin
              check("bubble", int'(tb_valid), 0);
            end
          end
        end
      end else begin
        step();
      end
    end
    check("trace_done", int'(done), 1);
    if (mode == 2) check("hold_cycles", hold, 3);
  endtask

  initial begin
    int n, s;
    for (int i = 0; i <= N; i++) for (int j = 0; j <= N; j++) refm[i][j] = 0;

    #2;
    reset_check("por");
    #10 rst = 1'b1;
    step();

    // Border initialisation and debug reads of it
    do_init();
    do_read(0, 0); do_read(0, 3); do_read(4, 0); do_read(0, 5); do_read(5, 0);
    do_read(6, 2); do_read(2, 7);

    // Pure diagonal path
    for (int k = 1; k <= N; k++) do_write(k, k, 4);
    run_trace(0);

    // Up then left then diagonal, with backpressure on the second beat
    do_write(5, 5, 2);
    do_write(4, 5, 1);
    run_trace(2);

    // Invalid symbol at the start cell, then init clears err
    do_write(5, 5, 0);
    run_trace(0);
    check("err_held_idle", int'(err), 1);
    do_init();
    do_read(5, 5);

    // Simultaneous start: init wins, fill write during INIT is dropped
    do_write(2, 3, 4);
    init_start = 1'b1; tb_start = 1'b1;
    step();
    init_start = 1'b0; tb_start = 1'b0;
    check("simul_no_busy", int'(tb_busy), 0);
    wr_en = 1'b1; wr_i = AW'(2); wr_j = AW'(3); wr_sym = 3'b001;
    step();
    wr_en = 1'b0;
    n = 1;
    while (!init_done && n < 50) begin
      check("simul_no_valid", int'(tb_valid), 0);
      step();
      n++;
    end
    check("simul_init_latency", n, 2*N+1);
    model_border();
    do_read(2, 3);

    // Asynchronous reset mid-traceback
    do_write(5, 5, 4);
    tb_start = 1'b1;
    step();
    tb_start = 1'b0;
    step(); step();
    rst = 1'b0;
    #1;
    reset_check("rst_trace");
    #1 rst = 1'b1;
    step();

    // Asynchronous reset mid-init, then a full re-init
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    repeat (4) step();
    rst = 1'b0;
    #1;
    reset_check("rst_init");
    #1 rst = 1'b1;
    step();
    do_init();

    // Randomised rounds: fill, stray writes, reads and a traceback
    for (int r = 0; r < 8; r++) begin
      if (r % 3 == 2) do_init();
      for (int i = 1; i <= N; i++) begin
        for (int j = 1; j <= N; j++) begin
          n = $urandom_range(0, 19);
          if (n < 6) s = 4;
          else if (n < 12) s = 2;
          else if (n < 18) s = 1;
          else s = $urandom_range(0, 7);
          do_write(i, j, s);
        end
      end
      repeat (3) do_write($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      repeat (6) do_read($urandom_range(0, 7), $urandom_range(0, 7));
      run_trace(1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/direction_matrix_ram.md
Name: direction_matrix_ram

Overview:
Parametrised direction memory for the Needleman-Wunsch core. It stores one direction symbol per cell of the (N+1)x(N+1) score matrix and initialises the gap border itself with an internal state machine. The fill stage writes interior cells. A built-in traceback engine walks from (N,N) back to (0,0) and streams the path to the alignment builder over a valid/ready handshake.

Parameters:
N, 5, sequence length; the matrix is (N+1)x(N+1) and indices run 0..N
SYM_W, 3, direction symbol width; encoding is diag=3'b100, up=3'b010, left=3'b001, none=3'b000
AW, $clog2(N+1), index width (derived localparam, not overridable)

Ports:
clk  in  1  single clock; all logic on the rising edge
rst  in  1  asynchronous, active-low reset
init_start  in  1  pulse: start border initialisation
init_done  out  1  one-cycle pulse when the border has been written
wr_en  in  1  fill-stage write strobe
wr_i, wr_j  in  AW  fill-stage cell coordinates
wr_sym  in  SYM_W  symbol to write
rd_en  in  1  debug random read strobe
rd_i, rd_j  in  AW  read coordinates
rd_sym  out  SYM_W  read data, valid 1 cycle after rd_en
tb_start  in  1  pulse: start traceback
tb_busy  out  1  high while traceback is in progress
tb_valid  out  1  traceback beat valid
tb_ready  in  1  downstream accepts the beat
tb_sym  out  SYM_W  direction symbol at the current cell
tb_i, tb_j  out  AW  coordinates of the current cell
tb_last  out  1  beat whose move reaches (0,0)
err  out  1  sticky traceback error; cleared by tb_start, init_start or reset

Behaviour:
- Linear address = i*(N+1)+j. Memory is synchronous with 1-cycle read latency. The array is not cleared by reset.
- Reset (asynchronous, rst=0): FSM goes to IDLE. All outputs are 0: init_done, rd_sym, tb_busy, tb_valid, tb_sym, tb_i, tb_j, tb_last, err.
- FSM states: IDLE, INIT, TB_FETCH, TB_OUT.
- IDLE:
  - init_start -> INIT.
  - Otherwise, tb_start -> TB_FETCH.
  - If both are high, init_start wins and tb_start is dropped.
- INIT: a counter k runs 0..2N, one write per cycle.
  - k=0 writes (0,0)=000.
  - k=1..N writes (0,k)=left.
  - k=N+1..2N writes (k-N,0)=up.
  - After the last write, init_done pulses for one cycle and the FSM returns to IDLE.
  - Total is 2N+1 cycles from init_start to the cycle before init_done. Interior cells are untouched.
- Fill writes (wr_en):
  - Accepted only in IDLE; ignored in INIT, TB_FETCH and TB_OUT.
  - Ignored if wr_i>N or wr_j>N.
  - Writes to border cells are allowed, and the last write wins.
- Debug reads (rd_en):
  - Serviced only in IDLE; rd_sym updates 1 cycle later.
  - Returns 000 for out-of-range coordinates.
  - Outside IDLE, rd_sym holds its value.
- Traceback:
  - On tb_start, tb_i=N and tb_j=N are loaded, tb_busy=1, err cleared, and the FSM enters TB_FETCH (read issued).
  - The next cycle is TB_OUT: tb_sym holds the read data and tb_valid=1. So tb_valid first rises 2 cycles after tb_start is sampled.
  - While tb_valid=1 and tb_ready=0, tb_sym, tb_i, tb_j and tb_last are held stable.
  - On handshake (tb_valid and tb_ready): diag decrements i and j; up decrements i; left decrements j.
  - If the new coordinate is (0,0), the FSM goes to IDLE with tb_busy=0. Otherwise it returns to TB_FETCH, leaving one bubble cycle between beats.
  - tb_last=1 on the beat whose move yields (0,0).
- Traceback errors: in TB_OUT, err=1, tb_valid stays 0 and the FSM aborts to IDLE with tb_busy=0 if either:
  - the fetched symbol is 000 or not one-hot, or
  - the move would underflow (up at i=0, left at j=0, diag at i=0 or j=0).
- Zero-length case (N,N)=(0,0) cannot occur for N≥1.
- Reset mid-INIT or mid-traceback:
  - Immediately returns to IDLE with outputs 0.
  - Border contents are undefined until init_start is reissued.

Test Plan:
- Reset, init_start; after 11 cycles (N=5) init_done pulses. Debug reads give (0,0)=000, (0,3)=001, (4,0)=010, (0,5)=001, (5,0)=010.
- Write diag at every (k,k), k=1..5; tb_start with tb_ready=1 -> 5 beats (5,5),(4,4),(3,3),(2,2),(1,1), all sym 100, tb_last only on (1,1), tb_busy falls after the last beat.
- Write (5,5)=010, (4,5)=001, (4,4)..(1,1)=100 -> beats (5,5)/010, (4,5)/001, (4,4)..(1,1)/100, then tb_last on (1,1).
- Backpressure: hold tb_ready=0 for 3 cycles on the second beat -> tb_valid stays 1 and tb_sym/tb_i/tb_j are unchanged; no beat is lost or duplicated.
- Write (5,5)=000, tb_start -> err=1 in the TB_OUT cycle, tb_valid never asserts, FSM returns to IDLE; a following init_start clears err.
- Assert rst low mid-traceback and mid-init, and separately assert init_start and tb_start together in IDLE:
  - Reset -> all outputs 0 asynchronously.
  - Simultaneous start -> INIT runs, no traceback; wr_en during INIT leaves the target cell unchanged.
